// File: rtl/risp_arbitro_sorgenti.sv
// rtl/risp_arbitro_sorgenti.sv - round-robin arbiter for the UDP response path
//
// Shares one risp_event/lcode/lung/data/valid stream among N_SRC result
// sources. A granted source gets its burst announced, then streams its words
// under transport back-pressure. A starved source is padded with zero words
// so that the delivered length always matches the announced one.
//
// Ports:
//   clk, i_rst_n              clock, synchronous active-low reset
//   i_req/i_lung              per-source burst request (level) and length
//   i_data/i_valid/od_ready   per-source word stream handshake
//   od_gnt                    one-hot grant, held for the whole service
//   od_done                   one-cycle pulse at burst end
//   i_busy                    transport back-pressure
//   od_risp_event/lcode/lung  burst announcement (source index, length)
//   od_risp_data/valid        output word stream, one cycle after transfer
//   od_errore                 sticky: [0] zero length, [1] clipped, [2] padded
//   od_attivo                 high whenever a burst is being serviced

module risp_arbitro_sorgenti #(
  parameter int N_SRC    = 3,
  parameter int LUNG_W   = 16,
  parameter int MAX_LUNG = 2048,
  parameter int TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic [N_SRC-1:0]        i_req,
  input  logic [N_SRC*LUNG_W-1:0] i_lung,
  input  logic [N_SRC*32-1:0]     i_data,
  input  logic [N_SRC-1:0]        i_valid,
  output logic [N_SRC-1:0]        od_ready,
  output logic [N_SRC-1:0]        od_gnt,
  output logic [N_SRC-1:0]        od_done,
  input  logic                    i_busy,
  output logic                    od_risp_event,
  output logic [1:0]              od_risp_lcode,
  output logic [LUNG_W-1:0]       od_risp_lung,
  output logic [31:0]             od_risp_data,
  output logic                    od_risp_valid,
  output logic [2:0]              od_errore,
  output logic                    od_attivo
);

  localparam int CNT_W = LUNG_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [LUNG_W-1:0] MAX_L   = LUNG_W'(MAX_LUNG);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ANNUNCIO,
    S_FLUSSO,
    S_RIEMPI,
    S_FINE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_g;
  logic [N_SRC-1:0]    r_gnt;
  logic [N_SRC-1:0]    r_done;
  logic [LUNG_W-1:0]   r_lung;
  logic [CNT_W-1:0]    r_cnt;
  logic [TO_W-1:0]     r_tcnt;
  logic                r_event;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [2:0]          r_err;

  logic                w_any;
  logic [1:0]          w_sel;
  logic [N_SRC-1:0]    w_sel_oh;
  logic [LUNG_W-1:0]   w_sel_lung;
  logic                w_valid_g;
  logic [31:0]         w_data_g;
  logic                w_xfer;
  logic                w_starve;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last;
  logic [1:0]          w_ptr_next;

  // Round-robin pick: lowest requester at or above the pointer, otherwise
  // lowest requester overall (which is then necessarily below the pointer).
  // Loops run downward so the lowest matching index is the one that sticks.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i] && (2'(i) >= r_ptr)) begin
        w_any = 1'b1;
        w_sel = 2'(i);
      end
    end
    if (!w_any) begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          w_any = 1'b1;
          w_sel = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_oh   = '0;
    w_sel_lung = '0;
    w_valid_g  = 1'b0;
    w_data_g   = '0;
    od_ready   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_sel_oh[i] = (w_sel == 2'(i));
      if (w_sel == 2'(i)) w_sel_lung = i_lung[i*LUNG_W +: LUNG_W];
      if (r_g == 2'(i)) begin
        w_valid_g = i_valid[i];
        w_data_g  = i_data[i*32 +: 32];
      end
      od_ready[i] = (r_state == S_FLUSSO) && !i_busy && (r_g == 2'(i));
    end
  end

  assign w_xfer     = (r_state == S_FLUSSO) && !i_busy && w_valid_g;
  assign w_starve   = (r_state == S_FLUSSO) && !i_busy && !w_valid_g;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_last     = (w_cnt_inc == {1'b0, r_lung});
  assign w_ptr_next = (r_g == 2'(N_SRC - 1)) ? 2'd0 : r_g + 2'd1;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_lung  <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_event <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= '0;
    end else begin
      r_event <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g    <= w_sel;
            r_gnt  <= w_sel_oh;
            r_cnt  <= '0;
            r_tcnt <= '0;
            if (w_sel_lung == '0) begin
              // Nothing to send: skip the announcement, just close the burst.
              r_err[0] <= 1'b1;
              r_lung   <= '0;
              r_done   <= w_sel_oh;
              r_state  <= S_FINE;
            end else begin
              r_event <= 1'b1;
              r_state <= S_ANNUNCIO;
              if (w_sel_lung > MAX_L) begin
                r_lung   <= MAX_L;
                r_err[1] <= 1'b1;
              end else begin
                r_lung <= w_sel_lung;
              end
            end
          end
        end
        S_ANNUNCIO: begin
          r_state <= S_FLUSSO;
        end
        S_FLUSSO: begin
          if (w_xfer) begin
            r_data  <= w_data_g;
            r_valid <= 1'b1;
            r_cnt   <= w_cnt_inc;
            r_tcnt  <= '0;
            if (w_last) begin
              r_done  <= r_gnt;
              r_state <= S_FINE;
            end
          end else if (w_starve) begin
            // Busy cycles are not the source's fault: only idle-ready cycles count.
            if (r_tcnt == TO_LAST) begin
              r_err[2] <= 1'b1;
              r_tcnt   <= '0;
              r_state  <= S_RIEMPI;
            end else begin
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end
        end
        S_RIEMPI: begin
          if (!i_busy) begin
            r_data  <= '0;
            r_valid <= 1'b1;
            r_cnt   <= w_cnt_inc;
            if (w_last) begin
              r_done  <= r_gnt;
              r_state <= S_FINE;
            end
          end
        end
        S_FINE: begin
          r_gnt   <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign od_gnt        = r_gnt;
  assign od_done       = r_done;
  assign od_risp_event = r_event;
  assign od_risp_lcode = r_g;
  assign od_risp_lung  = r_lung;
  assign od_risp_data  = r_data;
  assign od_risp_valid = r_valid;
  assign od_errore     = r_err;
  assign od_attivo     = (r_state != S_IDLE);

endmodule

// File: tb/tb_risp_arbitro_sorgenti.sv
// tb/tb_risp_arbitro_sorgenti.sv - directed self-checking bench for risp_arbitro_sorgenti

module tb_risp_arbitro_sorgenti;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [47:0] lung;
  logic [95:0] data;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic        ev;
  logic [1:0]  lcode;
  logic [15:0] rlung;
  logic [31:0] rdata;
  logic        rvalid;
  logic [2:0]  errore;
  logic        attivo;

  int n_cmp = 0;
  int n_bad = 0;

  int          src_cnt [3];
  int          valid_lim [3];
  logic [2:0]  valid_en;

  int          ev_cyc[$];
  logic [1:0]  ev_code[$];
  logic [15:0] ev_lung[$];
  logic [31:0] out_data[$];
  int          out_cyc[$];
  logic        out_pbusy[$];
  logic [2:0]  done_oh[$];
  int          done_cyc[$];
  int          err2_cyc;

  always #5 clk = ~clk;

  risp_arbitro_sorgenti #(
    .N_SRC(3), .LUNG_W(16), .MAX_LUNG(2048), .TIMEOUT(16)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lung(lung), .i_data(data),
    .i_valid(valid), .od_ready(ready), .od_gnt(gnt), .od_done(done),
    .i_busy(busy), .od_risp_event(ev), .od_risp_lcode(lcode),
    .od_risp_lung(rlung), .od_risp_data(rdata), .od_risp_valid(rvalid),
    .od_errore(errore), .od_attivo(attivo)
  );

  function automatic logic [31:0] exp_word(input int s, input int k);
    return 32'hA000_0000 | (32'(s) << 24) | 32'(k);
  endfunction

  // Source model: each source presents word k of its sequence until it is taken.
  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (!rst_n) src_cnt[s] <= 0;
      else if (ready[s] && valid[s]) src_cnt[s] <= src_cnt[s] + 1;
    end
  end

  always_comb begin
    data  = '0;
    valid = '0;
    for (int s = 0; s < 3; s++) begin
      data[s*32 +: 32] = exp_word(s, src_cnt[s]);
      valid[s] = valid_en[s] && (src_cnt[s] < valid_lim[s]);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    busy = 1'b0;
    lung = '0;
    valid_en = 3'b111;
    for (int s = 0; s < 3; s++) valid_lim[s] = 1000000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    ev_cyc.delete(); ev_code.delete(); ev_lung.delete();
    out_data.delete(); out_cyc.delete(); out_pbusy.delete();
    done_oh.delete(); done_cyc.delete();
    err2_cyc = -1;
  endtask

  // Runs cycles and logs what comes out; requesters drop i_req after od_done.
  task automatic collect(input int max_cyc, input int n_done, input bit tog_busy);
    int cyc;
    int seen;
    cyc = 0;
    seen = 0;
    clear_logs();
    while (seen < n_done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (ev) begin
        ev_cyc.push_back(cyc); ev_code.push_back(lcode); ev_lung.push_back(rlung);
      end
      if (rvalid) begin
        out_data.push_back(rdata); out_cyc.push_back(cyc); out_pbusy.push_back(busy);
      end
      if (errore[2] && err2_cyc < 0) err2_cyc = cyc;
      if (|done) begin
        done_oh.push_back(done); done_cyc.push_back(cyc);
        req = req & ~done;
        seen++;
      end
      if (tog_busy) busy = ~busy;
    end
    busy = 1'b0;
    n_cmp++;
    if (seen !== n_done) begin
      n_bad++;
      $display("FAIL collect_timeout: dones %0d, required %0d", seen, n_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; busy = 1'b0; lung = '0; valid_en = 3'b111;
    for (int s = 0; s < 3; s++) valid_lim[s] = 1000000;
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, ready, ev, lcode, rlung, rvalid, errore, attivo} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %h, required 0", {gnt, done, ready, ev, lcode, rlung, rvalid, errore, attivo});
    end
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h, required 0", rdata);
    end
  endtask

  task automatic test_single();
    do_reset();
    lung[15:0] = 16'd4;
    req = 3'b001;
    collect(40, 1, 1'b0);
    n_cmp++;
    if (ev_cyc.size() !== 1) begin
      n_bad++; $display("FAIL single_ev_count: got %0d, required 1", ev_cyc.size());
    end else begin
      n_cmp++;
      if (ev_cyc[0] !== 1 || ev_code[0] !== 2'd0 || ev_lung[0] !== 16'd4) begin
        n_bad++;
        $display("FAIL single_event: cyc %0d code %0d lung %0d, required 1 0 4", ev_cyc[0], ev_code[0], ev_lung[0]);
      end
    end
    n_cmp++;
    if (out_data.size() !== 4) begin
      n_bad++; $display("FAIL single_word_count: got %0d, required 4", out_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (out_data[k] !== exp_word(0, k) || out_cyc[k] !== 3 + k) begin
          n_bad++;
          $display("FAIL single_word%0d: %h at cyc %0d, required %h at cyc %0d", k, out_data[k], out_cyc[k], exp_word(0, k), 3 + k);
        end
      end
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] !== 6 || done_oh[0] !== 3'b001) begin
      n_bad++; $display("FAIL single_done: count %0d, required one pulse on src0 at cyc 6", done_cyc.size());
    end
    n_cmp++;
    if (errore !== 3'b000) begin
      n_bad++; $display("FAIL single_errore: got %b, required 000", errore);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_oh [3];
    exp_oh[0] = 3'b001; exp_oh[1] = 3'b010; exp_oh[2] = 3'b100;
    do_reset();
    lung = {16'd2, 16'd2, 16'd2};
    req = 3'b111;
    collect(60, 3, 1'b0);
    n_cmp++;
    if (done_oh.size() !== 3 || ev_code.size() !== 3) begin
      n_bad++; $display("FAIL rr_counts: dones %0d events %0d, required 3 3", done_oh.size(), ev_code.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (done_oh[i] !== exp_oh[i] || ev_code[i] !== 2'(i)) begin
          n_bad++;
          $display("FAIL rr_order%0d: done %b code %0d, required %b %0d", i, done_oh[i], ev_code[i], exp_oh[i], i);
        end
      end
    end
    n_cmp++;
    if (out_data.size() !== 6) begin
      n_bad++; $display("FAIL rr_word_count: got %0d, required 6", out_data.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (out_data[k] !== exp_word(k / 2, k % 2)) begin
          n_bad++; $display("FAIL rr_word%0d: got %h, required %h", k, out_data[k], exp_word(k / 2, k % 2));
        end
      end
    end
  endtask

  task automatic test_rr_pointer();
    do_reset();
    lung[15:0] = 16'd1;
    req = 3'b001;
    collect(20, 1, 1'b0);
    lung[31:16] = 16'd2;
    lung[47:32] = 16'd2;
    req = 3'b110;
    collect(40, 2, 1'b0);
    n_cmp++;
    if (done_oh.size() !== 2) begin
      n_bad++; $display("FAIL ptr_count: got %0d, required 2", done_oh.size());
    end else begin
      n_cmp++;
      if (done_oh[0] !== 3'b010 || done_oh[1] !== 3'b100) begin
        n_bad++; $display("FAIL ptr_order: got %b then %b, required 010 then 100", done_oh[0], done_oh[1]);
      end
    end
  endtask

  task automatic test_busy();
    do_reset();
    lung[31:16] = 16'd8;
    req = 3'b010;
    collect(80, 1, 1'b1);
    n_cmp++;
    if (out_data.size() !== 8) begin
      n_bad++; $display("FAIL busy_word_count: got %0d, required 8", out_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (out_data[k] !== exp_word(1, k) || out_pbusy[k] !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_word%0d: %h launched with busy=%b, required %h with busy=0", k, out_data[k], out_pbusy[k], exp_word(1, k));
        end
      end
    end
    n_cmp++;
    if (errore !== 3'b000) begin
      n_bad++; $display("FAIL busy_errore: got %b, required 000", errore);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    lung[47:32] = 16'd5;
    valid_lim[2] = 2;
    req = 3'b100;
    collect(80, 1, 1'b0);
    n_cmp++;
    if (err2_cyc !== 20) begin
      n_bad++; $display("FAIL timeout_flag_cyc: got %0d, required 20", err2_cyc);
    end
    n_cmp++;
    if (out_data.size() !== 5) begin
      n_bad++; $display("FAIL timeout_word_count: got %0d, required 5", out_data.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        logic [31:0] w;
        int c;
        w = (k < 2) ? exp_word(2, k) : 32'h0;
        c = (k < 2) ? 3 + k : 19 + k;
        n_cmp++;
        if (out_data[k] !== w || out_cyc[k] !== c) begin
          n_bad++;
          $display("FAIL timeout_word%0d: %h at cyc %0d, required %h at cyc %0d", k, out_data[k], out_cyc[k], w, c);
        end
      end
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] !== 23 || done_oh[0] !== 3'b100) begin
      n_bad++; $display("FAIL timeout_done: count %0d, required one pulse on src2 at cyc 23", done_cyc.size());
    end
    n_cmp++;
    if (errore !== 3'b100) begin
      n_bad++; $display("FAIL timeout_errore: got %b, required 100", errore);
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    req = 3'b001;
    collect(10, 1, 1'b0);
    n_cmp++;
    if (ev_cyc.size() !== 0 || out_data.size() !== 0) begin
      n_bad++; $display("FAIL zero_traffic: events %0d words %0d, required 0 0", ev_cyc.size(), out_data.size());
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] !== 1 || done_oh[0] !== 3'b001) begin
      n_bad++; $display("FAIL zero_done: count %0d, required one pulse on src0 at cyc 1", done_cyc.size());
    end
    n_cmp++;
    if (errore !== 3'b001) begin
      n_bad++; $display("FAIL zero_errore: got %b, required 001", errore);
    end
  endtask

  task automatic test_len_clip();
    int bad_words;
    do_reset();
    lung[31:16] = 16'd3000;
    req = 3'b010;
    collect(2300, 1, 1'b0);
    n_cmp++;
    if (ev_lung.size() != 1 || ev_lung[0] !== 16'd2048) begin
      n_bad++; $display("FAIL clip_event: events %0d, required one announcing 2048", ev_lung.size());
    end
    n_cmp++;
    if (out_data.size() !== 2048) begin
      n_bad++; $display("FAIL clip_word_count: got %0d, required 2048", out_data.size());
    end
    bad_words = 0;
    foreach (out_data[k]) if (out_data[k] !== exp_word(1, k)) bad_words++;
    n_cmp++;
    if (bad_words !== 0) begin
      n_bad++; $display("FAIL clip_words: %0d wrong words, required 0", bad_words);
    end
    n_cmp++;
    if (errore !== 3'b010) begin
      n_bad++; $display("FAIL clip_errore: got %b, required 010", errore);
    end
  endtask

  task automatic test_reset_mid_burst();
    int words;
    int dones;
    do_reset();
    lung[15:0] = 16'd1;
    req = 3'b001;
    collect(20, 1, 1'b0);
    lung[31:16] = 16'd10;
    req = 3'b010;
    words = 0;
    for (int c = 0; c < 40 && words < 3; c++) begin
      @(negedge clk);
      if (rvalid) words++;
    end
    n_cmp++;
    if (words !== 3) begin
      n_bad++; $display("FAIL mid_reach_word3: got %0d words, required 3", words);
    end
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    n_cmp++;
    if ({gnt, done, ready, ev, rlung, rvalid, rdata, errore, attivo} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h, required 0", {gnt, done, ready, ev, rlung, rvalid, rdata, errore, attivo});
    end
    dones = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (|done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL mid_no_done: got %0d pulses, required 0", dones);
    end
    lung[15:0] = 16'd1;
    lung[47:32] = 16'd1;
    req = 3'b101;
    collect(30, 2, 1'b0);
    n_cmp++;
    if (done_oh.size() != 2 || done_oh[0] !== 3'b001 || done_oh[1] !== 3'b100) begin
      n_bad++; $display("FAIL mid_fresh_order: count %0d, required src0 then src2", done_oh.size());
    end
  endtask

  initial begin
    err2_cyc = -1;
    test_reset();
    test_single();
    test_round_robin();
    test_rr_pointer();
    test_busy();
    test_timeout();
    test_len_zero();
    test_len_clip();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risp_arbitro_sorgenti.md
Name: risp_arbitro_sorgenti

Overview:
- Round-robin arbiter that shares the single UDP response path (the risp_event/lcode/data/valid stream into the transport layer) among several result sources: weight readback, network-error counter, true/false statistics.
- Each source requests a burst of N words. The arbiter grants one source, announces the burst, then streams its words under the transport's busy back-pressure.
- A stalled source is padded so the announced length always matches the delivered length.
- Sits between the network core's result ports and the payload/response processor.

Parameters:
- N_SRC, 3, number of requesting sources (1..4; source index is carried on a 2-bit code).
- LUNG_W, 16, width of burst length fields.
- MAX_LUNG, 2048, maximum burst length in words; longer requests are clipped.
- TIMEOUT, 1024, consecutive starved cycles (ready high, source valid low) before padding starts.

Ports:
- clk  in  1  system clock (~200 MHz)
- i_rst_n  in  1  synchronous reset, active-low
- i_req  in  N_SRC  per-source burst request, level, held until od_done
- i_lung  in  N_SRC*LUNG_W  per-source burst length in words, stable while i_req high
- i_data  in  N_SRC*32  per-source data word
- i_valid  in  N_SRC  per-source data valid
- od_ready  out  N_SRC  per-source ready; a word transfers when od_ready[i] & i_valid[i]
- od_gnt  out  N_SRC  one-hot; high for the whole service of source i
- od_done  out  N_SRC  one-cycle pulse at burst end
- i_busy  in  1  transport back-pressure; no output word while high
- od_risp_event  out  1  one-cycle burst announcement
- od_risp_lcode  out  2  granted source index, valid with od_risp_event
- od_risp_lung  out  LUNG_W  announced (clipped) length, valid with od_risp_event
- od_risp_data  out  32  output word
- od_risp_valid  out  1  output word valid
- od_errore  out  3  sticky flags: [0] zero-length request, [1] length clipped, [2] timeout padding
- od_attivo  out  1  high in every state except IDLE

Behaviour:
- Reset (i_rst_n=0 at a clk edge):
  - state=IDLE; RR pointer=0; word and timeout counters=0.
  - All outputs 0, including od_errore.
  - Reset mid-burst abandons the burst with no done pulse.
- FSM states: IDLE, ANNUNCIO, FLUSSO, RIEMPI, FINE.
- IDLE:
  - If any i_req is high, select the first requesting index at or after the RR pointer, scanning upward with wrap-around.
  - Latch its length into L and go to ANNUNCIO.
  - If L=0: set od_errore[0] and go straight to FINE (no event, no data).
  - If L>MAX_LUNG: set L=MAX_LUNG and set od_errore[1].
  - od_gnt[g] is asserted from the cycle after selection.
- ANNUNCIO (exactly 1 cycle):
  - od_risp_event=1, od_risp_lcode=g, od_risp_lung=L.
  - Next state FLUSSO.
- FLUSSO:
  - od_ready[g] = !i_busy (combinational); every other od_ready bit is 0.
  - On each transfer, register the word into od_risp_data with od_risp_valid=1 on the next cycle (1-cycle latency) and increment the word counter.
  - When the L-th word transfers, go to FINE.
  - The timeout counter increments on cycles with !i_busy & !i_valid[g] and clears on any transfer. Cycles with i_busy high neither increment nor clear it.
  - When the timeout counter reaches TIMEOUT, set od_errore[2] and go to RIEMPI.
- RIEMPI:
  - od_ready=0.
  - Emit od_risp_data=0 with od_risp_valid=1 on each cycle i_busy=0, until the total word count equals L.
  - Then go to FINE.
- FINE (1 cycle):
  - od_done[g]=1.
  - od_gnt drops at the end of this cycle.
  - RR pointer = (g+1) mod N_SRC.
  - Next state IDLE.
- Requester obligations:
  - The requester drops i_req on the edge after od_done. A request still high in IDLE is treated as a new burst.
  - Minimum gap between bursts: one IDLE cycle.
- Simultaneous events:
  - New requests arriving during a burst wait.
  - i_busy rising in the same cycle as i_valid blocks that transfer.
  - The last word of a burst and a new request in the same cycle: the new request is served after FINE and IDLE.
- Arithmetic: word count is L exactly, with no off-by-one; the counter is LUNG_W+1 bits wide to avoid wrap at MAX_LUNG.
- od_errore bits are sticky until reset.

Test Plan:
- Single source 0, i_lung=4, i_valid always high, i_busy=0:
  - event with lcode=0 and lung=4 one cycle after i_req is sampled.
  - 4 consecutive od_risp_valid words equal to the input words, 1-cycle latency.
  - od_done[0] one cycle after the last transfer.
- All 3 sources request together, each with lung=2:
  - service order 0,1,2.
  - After reset, then sources 2 and 1 requesting with pointer=1: order 1 then 2.
- Source 1, lung=8, i_busy toggled 1/0 every cycle:
  - exactly 8 valid output words, none emitted during busy cycles.
  - od_errore stays 0.
- Source 2, lung=5, stops valid after 2 words, TIMEOUT=16:
  - after 16 starved cycles, od_errore[2]=1.
  - 3 zero words emitted, then od_done[2].
  - Total valid words = 5.
- Edge lengths:
  - lung=0 gives no event, od_done pulse, od_errore[0]=1.
  - lung=3000 gives event lung=2048, 2048 words, od_errore[1]=1.
- i_rst_n=0 during word 3 of 10:
  - all outputs 0 next cycle, no od_done.
  - A fresh request afterwards is served from source 0 priority.
